fifo_async_read_ptr_ctrl: RTL and testbench



---
 rtl/fifo_async_read_ptr_ctrl.sv | 135 +++++++++++++
 tb/tb_fifo_async_read_ptr_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_async_read_ptr_ctrl.sv
// Read-domain pointer and flag controller for an asynchronous FIFO.
// Runs on RCLK. It owns the binary and Gray read pointers and drives the RAM
// read address. The write-side Gray pointer is brought in through a 2-FF
// synchronizer. EMPTY, ALMOST_EMPTY, LEVEL, RD_VALID and a sticky UNDERFLOW
// flag are all registered.
//
// Read handshake: R_EN is a request. It is accepted (rd_ok) only while the
// registered EMPTY is low. An accepted read advances the pointer on that edge,
// and RD_VALID is high in the following cycle, when the registered RAM output
// holds the word addressed by RADDR during the accept cycle. A request made
// while EMPTY is high is not accepted. It sets UNDERFLOW and does not move the
// pointers.
module fifo_async_read_ptr_ctrl #(
    parameter int PTR_WIDTH = 4,
    parameter int AE_THRESH = 1
) (
    input  logic                 RCLK,
    input  logic                 NRST,
    input  logic                 R_EN,
    input  logic                 CLR_ERR,
    input  logic [PTR_WIDTH-1:0] WPTR_G,
    output logic [PTR_WIDTH-2:0] RADDR,
    output logic [PTR_WIDTH-1:0] RPTR_B,
    output logic [PTR_WIDTH-1:0] RPTR_G,
    output logic                 EMPTY,
    output logic                 ALMOST_EMPTY,
    output logic [PTR_WIDTH-1:0] LEVEL,
    output logic                 RD_VALID,
    output logic                 UNDERFLOW
);

    // Threshold in pointer arithmetic width. The legal range (0..depth-1)
    // always fits.
    localparam logic [PTR_WIDTH-1:0] AE_TH = PTR_WIDTH'(AE_THRESH);

    // Gray to binary. Each binary bit is the XOR of all Gray bits at or above
    // it.
    function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] g);
        logic [PTR_WIDTH-1:0] b;
        b[PTR_WIDTH-1] = g[PTR_WIDTH-1];
        for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Synchronizer stages. Only the second stage is ever used.
    logic [PTR_WIDTH-1:0] wsync1_q;
    logic [PTR_WIDTH-1:0] wsync2_q;

    // Pointer and flag state.
    logic [PTR_WIDTH-1:0] rptr_b_q,    rptr_b_d;
    logic [PTR_WIDTH-1:0] rptr_g_q,    rptr_g_d;
    logic                 empty_q,     empty_d;
    logic                 aempty_q,    aempty_d;
    logic [PTR_WIDTH-1:0] level_q,     level_d;
    logic                 rd_valid_q,  rd_valid_d;
    logic                 underflow_q, underflow_d;

    logic                 rd_ok;
    logic [PTR_WIDTH-1:0] wptr_b_sync;

    // Bring the write pointer into RCLK. Gray coding limits any sampling
    // ambiguity to one step.
    always_ff @(posedge RCLK or negedge NRST) begin
        if (!NRST) begin
            wsync1_q <= '0;
            wsync2_q <= '0;
        end else begin
            wsync1_q <= WPTR_G;
            wsync2_q <= wsync1_q;
        end
    end

    // Next-state logic. A read is accepted only against the registered EMPTY.
    // Flags use the post-increment pointer, so an accepted read is reflected
    // at the same edge.
    always_comb begin
        wptr_b_sync = gray2bin(wsync2_q);
        rd_ok       = R_EN & ~empty_q;

        rptr_b_d    = rptr_b_q + PTR_WIDTH'(rd_ok);
        rptr_g_d    = (rptr_b_d >> 1) ^ rptr_b_d;

        // Gray comparison over the full width, wrap bit included.
        empty_d     = (rptr_g_d == wsync2_q);
        level_d     = wptr_b_sync - rptr_b_d;
        aempty_d    = (level_d <= AE_TH);

        rd_valid_d  = rd_ok;

        // A new underflow in the same cycle takes priority over CLR_ERR.
        if (R_EN && empty_q) begin
            underflow_d = 1'b1;
        end else if (CLR_ERR) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Register the pointers and flags. Reset leaves the FIFO logically empty.
    always_ff @(posedge RCLK or negedge NRST) begin
        if (!NRST) begin
            rptr_b_q    <= '0;
            rptr_g_q    <= '0;
            empty_q     <= 1'b1;
            aempty_q    <= 1'b1;
            level_q     <= '0;
            rd_valid_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rptr_b_q    <= rptr_b_d;
            rptr_g_q    <= rptr_g_d;
            empty_q     <= empty_d;
            aempty_q    <= aempty_d;
            level_q     <= level_d;
            rd_valid_q  <= rd_valid_d;
            underflow_q <= underflow_d;
        end
    end

    // Outputs come straight from registers. The RAM address drops the wrap bit.
    always_comb begin
        RADDR        = rptr_b_q[PTR_WIDTH-2:0];
        RPTR_B       = rptr_b_q;
        RPTR_G       = rptr_g_q;
        EMPTY        = empty_q;
        ALMOST_EMPTY = aempty_q;
        LEVEL        = level_q;
        RD_VALID     = rd_valid_q;
        UNDERFLOW    = underflow_q;
    end

endmodule

// File: tb/tb_fifo_async_read_ptr_ctrl.sv
// Bench for fifo_async_read_ptr_ctrl.
// The reference model counts words written and read as plain integers. Words
// written become visible to the read side two edges after they are driven.
// The stimulus pushes one expectation per edge. The monitor pops and compares
// on the falling edge.
module tb_fifo_async_read_ptr_ctrl;

  localparam int PW    = 4;
  localparam int DEPTH = 8;
  localparam int MOD   = 16;
  localparam int AE    = 1;

  // clock / reset
  logic          clk;
  logic          NRST;
  logic          R_EN;
  logic          CLR_ERR;
  logic [PW-1:0] WPTR_G;
  logic [PW-2:0] RADDR;
  logic [PW-1:0] RPTR_B;
  logic [PW-1:0] RPTR_G;
  logic          EMPTY;
  logic          ALMOST_EMPTY;
  logic [PW-1:0] LEVEL;
  logic          RD_VALID;
  logic          UNDERFLOW;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fifo_async_read_ptr_ctrl #(.PTR_WIDTH(PW), .AE_THRESH(AE)) dut (
    .RCLK(clk), .NRST(NRST), .R_EN(R_EN), .CLR_ERR(CLR_ERR), .WPTR_G(WPTR_G),
    .RADDR(RADDR), .RPTR_B(RPTR_B), .RPTR_G(RPTR_G), .EMPTY(EMPTY),
    .ALMOST_EMPTY(ALMOST_EMPTY), .LEVEL(LEVEL), .RD_VALID(RD_VALID),
    .UNDERFLOW(UNDERFLOW)
  );

  // scoreboard
  typedef struct {
    int rptr_b; int rptr_g; int raddr; int empty; int ae;
    int level;  int rd_valid; int uf;  int rd_addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state: totals of words written / read
  int wr_in;
  int rd_cnt;
  int vis_q[$];
  bit empty_m;
  bit uf_m;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic int to_gray(int v);
    int b;
    b = v % MOD;
    return b ^ (b >> 1);
  endfunction

  function automatic void model_reset();
    wr_in   = 0;
    rd_cnt  = 0;
    vis_q   = '{0, 0};
    empty_m = 1'b1;
    uf_m    = 1'b0;
  endfunction

  // Predicts the registered outputs after the coming edge.
  function automatic exp_t model_step(bit r_en, bit clr);
    exp_t e;
    int   vis;
    bit   acc;
    int   lvl;
    vis = vis_q.pop_front();
    vis_q.push_back(wr_in);
    acc = r_en && !empty_m;
    e.rd_addr = rd_cnt % DEPTH;
    if (r_en && empty_m) uf_m = 1'b1;
    else if (clr)        uf_m = 1'b0;
    if (acc) rd_cnt++;
    lvl = vis - rd_cnt;
    empty_m    = (lvl == 0);
    e.level    = lvl;
    e.empty    = (lvl == 0) ? 1 : 0;
    e.ae       = (lvl <= AE) ? 1 : 0;
    e.rd_valid = acc ? 1 : 0;
    e.uf       = uf_m ? 1 : 0;
    e.rptr_b   = rd_cnt % MOD;
    e.rptr_g   = to_gray(rd_cnt);
    e.raddr    = rd_cnt % DEPTH;
    return e;
  endfunction

  // driver tasks (entered at posedge+2 or earlier in the low phase)
  task automatic do_cycle(input bit r_en, input bit clr, input int wr_add);
    exp_t e;
    wr_in   = wr_in + wr_add;
    R_EN    = r_en;
    CLR_ERR = clr;
    WPTR_G  = PW'(to_gray(wr_in));
    e = model_step(r_en, clr);
    @(posedge clk);
    exp_q.push_back(e);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_empty"}, EMPTY, 1);
    chk({tag, "_ae"}, ALMOST_EMPTY, 1);
    chk({tag, "_level"}, LEVEL, 0);
    chk({tag, "_rptr_b"}, RPTR_B, 0);
    chk({tag, "_rptr_g"}, RPTR_G, 0);
    chk({tag, "_raddr"}, RADDR, 0);
    chk({tag, "_rd_valid"}, RD_VALID, 0);
    chk({tag, "_uf"}, UNDERFLOW, 0);
  endtask

  // Must be entered after the monitor has consumed the last expectation.
  task automatic do_reset(input string tag);
    NRST    = 1'b0;
    R_EN    = 1'b0;
    CLR_ERR = 1'b0;
    WPTR_G  = '0;
    model_reset();
    #1;
    check_reset_vals(tag);
    repeat (2) @(posedge clk);
    #2 NRST = 1'b1;
  endtask

  // monitor
  exp_t m_e;
  int   raddr_prev = 0;
  always @(negedge clk) begin
    if (NRST && exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      chk("rptr_b", int'(RPTR_B), m_e.rptr_b);
      chk("rptr_g", int'(RPTR_G), m_e.rptr_g);
      chk("raddr", int'(RADDR), m_e.raddr);
      chk("empty", int'(EMPTY), m_e.empty);
      chk("almost_empty", int'(ALMOST_EMPTY), m_e.ae);
      chk("level", int'(LEVEL), m_e.level);
      chk("rd_valid", int'(RD_VALID), m_e.rd_valid);
      chk("underflow", int'(UNDERFLOW), m_e.uf);
      if (m_e.rd_valid != 0) chk("rd_addr", raddr_prev, m_e.rd_addr);
    end
    raddr_prev = int'(RADDR);
  end

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    NRST = 1'b1; R_EN = 1'b0; CLR_ERR = 1'b0; WPTR_G = '0;
    model_reset();
    #1;
    do_reset("reset0");

    // empty reads underflow without moving pointers, then clear
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 0);
    do_cycle(1'b0, 1'b1, 0);

    // one write becomes visible two edges later
    do_cycle(1'b0, 1'b0, 1);
    idle(3);

    // three words, read back-to-back down to empty, then one extra read
    do_cycle(1'b0, 1'b0, 2);
    idle(3);
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 0);
    do_cycle(1'b1, 1'b0, 0);
    do_cycle(1'b0, 1'b1, 0);

    // level 1, then a read on the same edge as a newly synchronized write
    do_cycle(1'b0, 1'b0, 1);
    idle(3);
    do_cycle(1'b0, 1'b0, 1);
    do_cycle(1'b0, 1'b0, 0);
    do_cycle(1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 0);
    settle();

    // full FIFO, read 16 words while the writer wraps
    do_reset("reset1");
    do_cycle(1'b0, 1'b0, 8);
    idle(3);
    for (int i = 0; i < 60 && rd_cnt < 16; i++) begin
      do_cycle(1'b1, 1'b0, (wr_in < 16 && wr_in - rd_cnt < DEPTH) ? 1 : 0);
    end
    chk("wrap_reads", rd_cnt, 16);
    idle(3);
    settle();

    // asynchronous reset in the middle of a burst at level 5
    do_reset("reset2");
    do_cycle(1'b0, 1'b0, 8);
    idle(3);
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 0);
    settle();
    chk("pre_reset_level", int'(LEVEL), 5);
    do_reset("midreset");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int add;
      add = 0;
      if (wr_in - rd_cnt < DEPTH && $urandom_range(0, 99) < 45) add = 1;
      do_cycle(($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
               ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0, add);
    end
    settle();

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
